// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe move controller: owns the board registers, validates moves and samples the win checker.
// Optional per-turn forfeit timer is built when MOVE_TIMEOUT_EN is defined.
module ttt_board_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  input  logic [1:0] gs_in,
  output logic [8:0] val,
  output logic [8:0] sym,
  output logic       turn,
  output logic [3:0] move_cnt,
  output logic       move_err,
  output logic [1:0] err_code,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw
);

  typedef enum logic [1:0] {StPlay, StEval, StOver} state_e;

  state_e state;

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned TcntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYCLES - 1);
  logic [TcntW-1:0] tcnt;
  logic             expired;
  assign expired = (tcnt == TcntLast);
`endif

  assign move_ready = (state == StPlay);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StPlay;
      val       <= '0;
      sym       <= '0;
      turn      <= 1'b1;
      move_cnt  <= '0;
      move_err  <= 1'b0;
      err_code  <= 2'b00;
      game_over <= 1'b0;
      winner    <= 2'b00;
      draw      <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      move_err <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      // Counter only runs while waiting in PLAY; any other state re-arms it.
      tcnt <= (state == StPlay && !new_game) ? tcnt + 1'b1 : '0;
`endif
      if (new_game) begin
        // err_code deliberately survives a new game; a concurrent move is dropped.
        state     <= StPlay;
        val       <= '0;
        sym       <= '0;
        turn      <= 1'b1;
        move_cnt  <= '0;
        game_over <= 1'b0;
        winner    <= 2'b00;
        draw      <= 1'b0;
      end else begin
        unique case (state)
          StPlay: begin
            if (move_valid && move_pos <= 4'd8 && !val[move_pos]) begin
              val[move_pos] <= 1'b1;
              sym[move_pos] <= turn;
              move_cnt      <= move_cnt + 4'd1;
              state         <= StEval;
            end else begin
              if (move_valid) begin
                move_err <= 1'b1;
                err_code <= (move_pos > 4'd8) ? 2'b01 : 2'b10;
              end
`ifdef MOVE_TIMEOUT_EN
              if (expired) begin
                winner    <= turn ? 2'b10 : 2'b01;
                game_over <= 1'b1;
                state     <= StOver;
              end
`endif
            end
          end
          StEval: begin
            if (move_valid) begin
              move_err <= 1'b1;
              err_code <= 2'b11;
            end
            if (gs_in[0]) begin
              winner    <= 2'b01;
              game_over <= 1'b1;
              state     <= StOver;
            end else if (gs_in[1]) begin
              winner    <= 2'b10;
              game_over <= 1'b1;
              state     <= StOver;
            end else if (move_cnt == 4'd9) begin
              draw      <= 1'b1;
              game_over <= 1'b1;
              state     <= StOver;
            end else begin
              turn  <= ~turn;
              state <= StPlay;
            end
          end
          StOver: begin
            if (move_valid) begin
              move_err <= 1'b1;
              err_code <= 2'b11;
            end
          end
          default: state <= StPlay;
        endcase
      end
    end
  end

endmodule
